// File: rtl/lockstep_mon_pkg.sv
// Shared state encoding and default geometry for the two-copy lockstep divergence monitor.
package lockstep_mon_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RESET_HOLD,
    SETTLE,
    OBSERVE,
    DONE
  } mon_state_t;

  localparam int unsigned DEF_NUM_CH        = 4;
  localparam int unsigned DEF_AW            = 32;
  localparam int unsigned DEF_DW            = 32;
  localparam int unsigned DEF_RESET_CYCLES  = 2;
  localparam int unsigned DEF_SETTLE_CYCLES = 6;
  localparam int unsigned DEF_WINDOW        = 16;
  localparam int unsigned DEF_CW            = 8;

endpackage

// File: rtl/lockstep_div_cmp.sv
// Single-channel A/B comparator: valid/addr mismatch, plus data mismatch when
// LOCKSTEP_DATA_CMP_EN is defined. A disabled channel never reports divergence.
module lockstep_div_cmp #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          en,
  input  logic          valid_a,
  input  logic          valid_b,
  input  logic [AW-1:0] addr_a,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] data_a,
  input  logic [DW-1:0] data_b,
  output logic          div
);

  logic both_valid;
  logic field_mismatch;

  assign both_valid = valid_a & valid_b;

`ifdef LOCKSTEP_DATA_CMP_EN
  assign field_mismatch = (addr_a != addr_b) || (data_a != data_b);
`else
  logic unused_data;
  assign unused_data    = ^{data_a, data_b};
  assign field_mismatch = (addr_a != addr_b);
`endif

  assign div = en & ((valid_a ^ valid_b) | (both_valid & field_mismatch));

endmodule

// File: rtl/lockstep_divergence_monitor.sv
// Two-copy lockstep observer: sequences core reset, requests equal initial state, then
// latches the first A/B channel divergence over a bounded window. Option: LOCKSTEP_DATA_CMP_EN.
module lockstep_divergence_monitor
  import lockstep_mon_pkg::*;
#(
  parameter int unsigned NUM_CH        = DEF_NUM_CH,
  parameter int unsigned AW            = DEF_AW,
  parameter int unsigned DW            = DEF_DW,
  parameter int unsigned RESET_CYCLES  = DEF_RESET_CYCLES,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned WINDOW        = DEF_WINDOW,
  parameter int unsigned CW            = DEF_CW,
  localparam int unsigned CHW          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_CH-1:0]    ch_mask,
  input  logic [NUM_CH-1:0]    valid_a,
  input  logic [NUM_CH-1:0]    valid_b,
  input  logic [NUM_CH*AW-1:0] addr_a,
  input  logic [NUM_CH*AW-1:0] addr_b,
  input  logic [NUM_CH*DW-1:0] data_a,
  input  logic [NUM_CH*DW-1:0] data_b,
  output logic                 core_reset,
  output logic                 init_eq_req,
  output logic                 observing,
  output logic                 done,
  output logic                 diverged,
  output logic                 pass,
  output logic [NUM_CH-1:0]    div_vec,
  output logic [CHW-1:0]       first_div_ch,
  output logic [CW-1:0]        first_div_cycle
);

  localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] WIN_LAST = CW'(WINDOW - 1);

  mon_state_t        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
  logic              clear_verdict;
  logic [NUM_CH-1:0] ch_div;
  logic [NUM_CH-1:0] obs_div;
  logic [CHW-1:0]    lowest_ch;
  logic              lowest_found;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cmp
    lockstep_div_cmp #(.AW(AW), .DW(DW)) u_cmp (
      .en      (ch_mask[g]),
      .valid_a (valid_a[g]),
      .valid_b (valid_b[g]),
      .addr_a  (addr_a[g*AW +: AW]),
      .addr_b  (addr_b[g*AW +: AW]),
      .data_a  (data_a[g*DW +: DW]),
      .data_b  (data_b[g*DW +: DW]),
      .div     (ch_div[g])
    );
  end

  assign obs_div = (state_q == OBSERVE) ? ch_div : '0;

  always_comb begin
    lowest_ch    = '0;
    lowest_found = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (obs_div[i] && !lowest_found) begin
        lowest_ch    = CHW'(i);
        lowest_found = 1'b1;
      end
    end
  end

  // One counter serves every timed phase; it restarts from zero at each phase change.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_inc;
    clear_verdict = 1'b0;
    core_reset    = 1'b0;
    init_eq_req   = 1'b0;
    observing     = 1'b0;
    done          = 1'b0;
    unique case (state_q)
      IDLE: begin
        core_reset = 1'b1;
        cnt_d      = '0;
        if (start) begin
          state_d       = RESET_HOLD;
          clear_verdict = 1'b1;
        end
      end
      RESET_HOLD: begin
        core_reset = 1'b1;
        if (cnt_q == RST_LAST) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        init_eq_req = (cnt_q == '0);
        if (cnt_q == SET_LAST) begin
          state_d = OBSERVE;
          cnt_d   = '0;
        end
      end
      OBSERVE: begin
        observing = 1'b1;
        if (cnt_q == WIN_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      DONE: begin
        done  = 1'b1;
        cnt_d = '0;
        if (start) begin
          state_d       = RESET_HOLD;
          clear_verdict = 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        cnt_d      = '0;
        core_reset = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      diverged        <= 1'b0;
      div_vec         <= '0;
      first_div_ch    <= '0;
      first_div_cycle <= '0;
    end else if (clear_verdict) begin
      diverged        <= 1'b0;
      div_vec         <= '0;
      first_div_ch    <= '0;
      first_div_cycle <= '0;
    end else if (|obs_div) begin
      div_vec <= div_vec | obs_div;
      if (!diverged) begin
        diverged        <= 1'b1;
        first_div_ch    <= lowest_ch;
        first_div_cycle <= cnt_q;
      end
    end
  end

  assign pass = done & ~diverged;

endmodule

// File: tb/tb_lockstep_divergence_monitor.sv
// Directed bench for lockstep_divergence_monitor: timeline-based reference model checked
// every cycle, plus literal verdict expectations per scenario.
module tb_lockstep_divergence_monitor;

  localparam int NUM_CH = 4;
  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int R      = 2;
  localparam int S      = 6;
  localparam int W      = 16;
  localparam int CW     = 8;
  localparam int CHW    = 2;
  // Cycle t after the accepted start edge: hold 1..R, settle R+1..R+S, observe to R+S+W.
  localparam int OBS_FIRST = R + S + 1;
  localparam int OBS_LAST  = R + S + W;
  localparam int DONE_T    = OBS_LAST + 1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic [NUM_CH-1:0]    ch_mask, valid_a, valid_b;
  logic [NUM_CH*AW-1:0] addr_a, addr_b;
  logic [NUM_CH*DW-1:0] data_a, data_b;
  logic                 core_reset, init_eq_req, observing, done, diverged, pass;
  logic [NUM_CH-1:0]    div_vec;
  logic [CHW-1:0]       first_div_ch;
  logic [CW-1:0]        first_div_cycle;

  int checks   = 0;
  int failures = 0;

  lockstep_divergence_monitor #(
    .NUM_CH(NUM_CH), .AW(AW), .DW(DW), .RESET_CYCLES(R),
    .SETTLE_CYCLES(S), .WINDOW(W), .CW(CW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .ch_mask(ch_mask),
    .valid_a(valid_a), .valid_b(valid_b), .addr_a(addr_a), .addr_b(addr_b),
    .data_a(data_a), .data_b(data_b), .core_reset(core_reset),
    .init_eq_req(init_eq_req), .observing(observing), .done(done),
    .diverged(diverged), .pass(pass), .div_vec(div_vec),
    .first_div_ch(first_div_ch), .first_div_cycle(first_div_cycle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position in the run timeline plus verdict from the divergence rule.
  bit              m_started;
  int              m_t;
  bit              m_div;
  logic [NUM_CH-1:0] m_dv;
  int              m_fch, m_fcyc;

  always @(posedge clk or posedge reset) begin : model
    logic [NUM_CH-1:0] d;
    int lo;
    if (reset) begin
      m_started <= 1'b0; m_t <= 0; m_div <= 1'b0; m_dv <= '0; m_fch <= 0; m_fcyc <= 0;
    end else begin
      d = '0;
      if (m_started && m_t >= OBS_FIRST && m_t <= OBS_LAST) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (ch_mask[i]) begin
            d[i] = (valid_a[i] != valid_b[i]) ||
                   (valid_a[i] && valid_b[i] && addr_a[i*AW +: AW] != addr_b[i*AW +: AW]);
`ifdef LOCKSTEP_DATA_CMP_EN
            d[i] = d[i] || (valid_a[i] && valid_b[i] && data_a[i*DW +: DW] != data_b[i*DW +: DW]);
`endif
          end
        end
      end
      lo = -1;
      for (int i = NUM_CH - 1; i >= 0; i--) if (d[i]) lo = i;
      if (start && (!m_started || m_t >= DONE_T)) begin
        m_started <= 1'b1; m_t <= 1; m_div <= 1'b0; m_dv <= '0; m_fch <= 0; m_fcyc <= 0;
      end else begin
        if (m_started && m_t < DONE_T) m_t <= m_t + 1;
        if (lo >= 0) begin
          m_dv <= m_dv | d;
          if (!m_div) begin
            m_div <= 1'b1; m_fch <= lo; m_fcyc <= m_t - OBS_FIRST;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("core_reset", 32'(core_reset), 32'(!m_started || m_t <= R));
      chk("init_eq_req", 32'(init_eq_req), 32'(m_started && m_t == R + 1));
      chk("observing", 32'(observing), 32'(m_started && m_t >= OBS_FIRST && m_t <= OBS_LAST));
      chk("done", 32'(done), 32'(m_started && m_t >= DONE_T));
      chk("diverged", 32'(diverged), 32'(m_div));
      chk("pass", 32'(pass), 32'(m_started && m_t >= DONE_T && !m_div));
      chk("div_vec", 32'(div_vec), 32'(m_dv));
      chk("first_div_ch", 32'(first_div_ch), 32'(m_fch));
      chk("first_div_cycle", 32'(first_div_cycle), 32'(m_fcyc));
    end
  end

  task automatic drive(input int sc, input int t);
    valid_a = '1;
    valid_b = '1;
    for (int i = 0; i < NUM_CH; i++) begin
      addr_a[i*AW +: AW] = 32'(t * 16 + i);
      data_a[i*DW +: DW] = 32'(32'hA500 + t * 4 + i);
    end
    addr_b = addr_a;
    data_b = data_a;
    start  = (sc == 0 && t == 12);
    case (sc)
      1: if (t == 14) valid_b[2] = 1'b0;
      2: if (t == 9) begin
           addr_b[1*AW +: AW] = addr_b[1*AW +: AW] ^ 32'h1;
           addr_b[3*AW +: AW] = addr_b[3*AW +: AW] ^ 32'h100;
         end
      3: if (t == 12) data_b[0 +: DW] = data_b[0 +: DW] ^ 32'h1;
      4: begin
           if (t == 12) begin
             data_b[0 +: DW] = data_b[0 +: DW] ^ 32'h1;
             addr_b[0 +: AW] = addr_b[0 +: AW] ^ 32'h1;
           end
           if (t == 13) valid_b[0] = 1'b0;
         end
      5: begin
           if (t == 5) valid_a[0] = 1'b0;
           if (t == 24) addr_b[3*AW +: AW] = addr_b[3*AW +: AW] ^ 32'h2;
         end
      6: if (t == 10) addr_b[1*AW +: AW] = addr_b[1*AW +: AW] ^ 32'h4;
      default: ;
    endcase
  endtask

  // Called at posedge+1; leaves the bench at posedge+1 of cycle last_t+1.
  task automatic run(input int sc, input logic [NUM_CH-1:0] mask, input int last_t);
    ch_mask = mask;
    drive(-1, 0);
    start = 1'b1;
    @(posedge clk); #1;
    for (int t = 1; t <= last_t; t++) begin
      drive(sc, t);
      if (t == OBS_LAST) chk("not_done_last_obs", 32'(done), 32'd0);
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic verdict(input string tag, input logic dv, input logic ps,
                         input logic [NUM_CH-1:0] vec, input int ch, input int cyc);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_diverged"}, 32'(diverged), 32'(dv));
    chk({tag, "_pass"}, 32'(pass), 32'(ps));
    chk({tag, "_div_vec"}, 32'(div_vec), 32'(vec));
    chk({tag, "_ch"}, 32'(first_div_ch), 32'(ch));
    chk({tag, "_cycle"}, 32'(first_div_cycle), 32'(cyc));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; ch_mask = '0; valid_a = '0; valid_b = '0;
    addr_a = '0; addr_b = '0; data_a = '0; data_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_outputs", 32'({init_eq_req, observing, done, diverged, pass}), 32'd0);
    chk("rst_verdict", 32'({div_vec, first_div_ch, first_div_cycle}), 32'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    run(0, 4'hF, OBS_LAST);
    verdict("clean", 1'b0, 1'b1, 4'b0000, 0, 0);
    run(1, 4'hF, OBS_LAST);
    verdict("valid_ch2", 1'b1, 1'b0, 4'b0100, 2, 5);
    run(2, 4'hF, OBS_LAST);
    verdict("addr_ch1_ch3", 1'b1, 1'b0, 4'b1010, 1, 0);
    run(3, 4'hF, OBS_LAST);
`ifdef LOCKSTEP_DATA_CMP_EN
    verdict("data_ch0", 1'b1, 1'b0, 4'b0001, 0, 3);
`else
    verdict("data_ch0", 1'b0, 1'b1, 4'b0000, 0, 0);
`endif
    run(4, 4'b1110, OBS_LAST);
    verdict("masked_ch0", 1'b0, 1'b1, 4'b0000, 0, 0);
    run(5, 4'hF, OBS_LAST);
    verdict("settle_and_last", 1'b1, 1'b0, 4'b1000, 3, 15);

    run(6, 4'hF, 12);
    chk("mid_diverged", 32'(diverged), 32'd1);
    chk("mid_first_cycle", 32'(first_div_cycle), 32'd1);
    #3 reset = 1'b1;
    #1;
    chk("async_core_reset", 32'(core_reset), 32'd1);
    chk("async_observing", 32'(observing), 32'd0);
    chk("async_diverged", 32'(diverged), 32'd0);
    chk("async_div_vec", 32'(div_vec), 32'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    run(0, 4'hF, OBS_LAST);
    verdict("restart", 1'b0, 1'b1, 4'b0000, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
